// File: rtl/dino_motion_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dino_motion_ctrl
// Description : Tick-based jump/duck physics for the dino sprite foot row.
// Revision    : 1.0 - initial release
// ============================================================================
module dino_motion_ctrl #(
    parameter int TICK_CYCLES = 1000000,
    parameter int GROUND      = 298,
    parameter int JUMP_V0     = 12,
    parameter int GRAVITY     = 1,
    parameter int FAST_G      = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       jump,
    input  logic       duck,
    input  logic [1:0] game_state,
    output logic [9:0] pos,
    output logic       dino_behavior,
    output logic       airborne
);

    localparam int CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

    localparam logic [CNT_W-1:0]   c_tick_last = CNT_W'(TICK_CYCLES - 1);
    localparam logic [1:0]         c_gs_init   = 2'd0;
    localparam logic [1:0]         c_gs_start  = 2'd1;
    localparam logic [1:0]         c_gs_end    = 2'd2;
    localparam logic [1:0]         c_gs_reset  = 2'd3;
    localparam logic [9:0]         c_ground    = 10'(GROUND);
    localparam logic signed [10:0] c_ground_s  = 11'(GROUND);
    localparam logic [9:0]         c_jump_top  = 10'(GROUND - JUMP_V0);
    localparam logic signed [7:0]  c_v0        = 8'(JUMP_V0);
    localparam logic signed [7:0]  c_grav      = 8'(GRAVITY);
    localparam logic signed [7:0]  c_fast_g    = 8'(FAST_G);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_DUCK = 2'd1,
        ST_AIR  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_tick_cnt;
    logic               w_tick;
    logic               r_pend;
    logic               w_pend_nxt;
    logic               w_jump_req;
    logic signed [7:0]  r_vel;
    logic signed [7:0]  w_vel_nxt;
    logic [9:0]         w_pos_nxt;
    logic               w_behav_nxt;
    logic               w_air_nxt;
    logic signed [10:0] w_fall;

    assign w_tick     = (r_tick_cnt == c_tick_last);
    // A pulse arriving on the tick cycle itself is honoured on that tick.
    assign w_jump_req = r_pend | jump;
    assign w_fall     = $signed({1'b0, pos}) - $signed({{3{r_vel[7]}}, r_vel});

    always_ff @(posedge clk) begin
        if (rst || w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pos_nxt   = pos;
        w_vel_nxt   = r_vel;
        w_pend_nxt  = w_tick ? 1'b0 : w_jump_req;
        w_behav_nxt = dino_behavior;
        w_air_nxt   = airborne;

        case (game_state)
            c_gs_reset: begin
                w_state_nxt = ST_RUN;
                w_pos_nxt   = c_ground;
                w_vel_nxt   = '0;
                w_pend_nxt  = 1'b0;
            end
            c_gs_end: begin
                // frozen; only the pending flag keeps tracking pulses and ticks
            end
            c_gs_init: begin
                if (w_tick) begin
                    w_state_nxt = ST_RUN;
                    w_pos_nxt   = c_ground;
                    w_vel_nxt   = '0;
                end
            end
            c_gs_start: begin
                if (w_tick) begin
                    case (r_state)
                        ST_AIR: begin
                            if (w_fall >= c_ground_s) begin
                                w_pos_nxt   = c_ground;
                                w_vel_nxt   = '0;
                                w_state_nxt = duck ? ST_DUCK : ST_RUN;
                            end else begin
                                w_pos_nxt = (w_fall < 0) ? 10'd0 : w_fall[9:0];
                                w_vel_nxt = r_vel - (duck ? c_fast_g : c_grav);
                            end
                        end
                        default: begin
                            if (w_jump_req) begin
                                w_state_nxt = ST_AIR;
                                w_vel_nxt   = c_v0 - c_grav;
                                w_pos_nxt   = c_jump_top;
                            end else if (duck) begin
                                w_state_nxt = ST_DUCK;
                            end else begin
                                w_state_nxt = ST_RUN;
                            end
                        end
                    endcase
                end
            end
            default: begin
            end
        endcase

        if (game_state != c_gs_end) begin
            w_behav_nxt = (w_state_nxt != ST_DUCK);
            w_air_nxt   = (w_state_nxt == ST_AIR);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_RUN;
            pos           <= c_ground;
            r_vel         <= '0;
            r_pend        <= 1'b0;
            dino_behavior <= 1'b1;
            airborne      <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            pos           <= w_pos_nxt;
            r_vel         <= w_vel_nxt;
            r_pend        <= w_pend_nxt;
            dino_behavior <= w_behav_nxt;
            airborne      <= w_air_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dino_motion_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dino_motion_ctrl
// Description : Directed + randomized bench for dino_motion_ctrl with a
//               plain-integer physics reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dino_motion_ctrl;

    localparam int TCK  = 4;
    localparam int G    = 298;
    localparam int V0   = 12;
    localparam int GRAV = 1;
    localparam int FG   = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       jump = 1'b0;
    logic       duck = 1'b0;
    logic [1:0] game_state = 2'd1;
    logic [9:0] pos;
    logic       dino_behavior;
    logic       airborne;

    int checks   = 0;
    int failures = 0;

    // reference model: integer physics
    int m_cnt    = 0;
    int m_pos    = G;
    int m_vel    = 0;
    bit m_air    = 0;
    bit m_crouch = 0;
    bit m_pend   = 0;
    bit m_ticked = 0;

    dino_motion_ctrl #(
        .TICK_CYCLES(TCK),
        .GROUND     (G),
        .JUMP_V0    (V0),
        .GRAVITY    (GRAV),
        .FAST_G     (FG)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .jump         (jump),
        .duck         (duck),
        .game_state   (game_state),
        .pos          (pos),
        .dino_behavior(dino_behavior),
        .airborne     (airborne)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit tick;
        bit req;
        int nxt;
        tick = (m_cnt == TCK - 1);
        req  = m_pend || (jump === 1'b1);
        m_ticked = 0;
        if (rst) begin
            m_cnt = 0; m_pos = G; m_vel = 0; m_air = 0; m_crouch = 0; m_pend = 0;
            return;
        end
        m_ticked = tick;
        m_cnt    = tick ? 0 : m_cnt + 1;
        m_pend   = tick ? 0 : req;
        case (game_state)
            2'd3: begin
                m_pos = G; m_vel = 0; m_air = 0; m_crouch = 0; m_pend = 0;
            end
            2'd0: if (tick) begin
                m_pos = G; m_vel = 0; m_air = 0; m_crouch = 0;
            end
            2'd1: if (tick) begin
                if (m_air) begin
                    nxt = m_pos - m_vel;
                    if (nxt >= G) begin
                        m_pos = G; m_vel = 0; m_air = 0; m_crouch = duck;
                    end else begin
                        m_pos = (nxt < 0) ? 0 : nxt;
                        m_vel = m_vel - (duck ? FG : GRAV);
                    end
                end else if (req) begin
                    m_air = 1; m_crouch = 0; m_pos = G - V0; m_vel = V0 - GRAV;
                end else begin
                    m_crouch = duck;
                end
            end
            default: ;
        endcase
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        chk("model_pos",   {22'd0, pos},           m_pos);
        chk("model_behav", {31'd0, dino_behavior}, {31'd0, !m_crouch});
        chk("model_air",   {31'd0, airborne},      {31'd0, m_air});
    endtask

    task automatic wait_tick();
        int n;
        n = 0;
        do begin
            cyc();
            n++;
        end while (!m_ticked && n < 2 * TCK);
        if (!m_ticked) chk("tick_timeout", 32'd0, 32'd1);
    endtask

    // pulse on a cycle whose edge is not a tick, so the next tick takes it
    task automatic pulse_jump();
        int n;
        n = 0;
        while (m_cnt != 0 && n < 2 * TCK) begin
            cyc();
            n++;
        end
        jump = 1'b1;
        cyc();
        jump = 1'b0;
    endtask

    task automatic do_flight(input int second_at);
        int exp_pos;
        pulse_jump();
        for (int t = 1; t <= 25; t++) begin
            wait_tick();
            exp_pos = G - V0 * t + (t * (t - 1)) / 2;
            chk("traj_pos", {22'd0, pos}, exp_pos);
            chk("traj_air", {31'd0, airborne}, (t < 25) ? 32'd1 : 32'd0);
            if (t == second_at) begin
                jump = 1'b1;
                cyc();
                jump = 1'b0;
            end
        end
    endtask

    initial begin
        int land_t;
        int n;

        // reset
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        chk("reset_pos",   {22'd0, pos},           32'd298);
        chk("reset_behav", {31'd0, dino_behavior}, 32'd1);
        chk("reset_air",   {31'd0, airborne},      32'd0);

        // single jump, then jump with a second pulse at tick 5
        do_flight(0);
        do_flight(5);

        // duck on ground
        duck = 1'b1;
        wait_tick();
        chk("duck_behav", {31'd0, dino_behavior}, 32'd0);
        chk("duck_pos",   {22'd0, pos},           32'd298);
        duck = 1'b0;
        wait_tick();
        chk("unduck_behav", {31'd0, dino_behavior}, 32'd1);

        // fast fall after reaching the peak
        pulse_jump();
        for (int t = 1; t <= 12; t++) wait_tick();
        chk("peak_pos", {22'd0, pos}, 32'd220);
        duck = 1'b1;
        land_t = 0;
        for (int t = 13; t <= 25 && land_t == 0; t++) begin
            wait_tick();
            if (airborne === 1'b0) land_t = t;
        end
        chk("fast_land_tick",  land_t,                  32'd20);
        chk("fast_land_pos",   {22'd0, pos},            32'd298);
        chk("fast_land_behav", {31'd0, dino_behavior},  32'd0);
        duck = 1'b0;
        wait_tick();

        // jump ignored in INIT
        game_state = 2'd0;
        pulse_jump();
        wait_tick();
        wait_tick();
        chk("init_pos", {22'd0, pos},      32'd298);
        chk("init_air", {31'd0, airborne}, 32'd0);
        game_state = 2'd1;
        wait_tick();

        // freeze at 250 on the fast-fall descent, then game RESET
        pulse_jump();
        for (int t = 1; t <= 12; t++) wait_tick();
        duck = 1'b1;
        for (int t = 13; t <= 17; t++) wait_tick();
        chk("end_entry_pos", {22'd0, pos}, 32'd250);
        game_state = 2'd2;
        for (int k = 0; k < 10; k++) begin
            wait_tick();
            chk("end_hold_pos", {22'd0, pos},      32'd250);
            chk("end_hold_air", {31'd0, airborne}, 32'd1);
        end
        game_state = 2'd3;
        cyc();
        chk("greset_pos",   {22'd0, pos},           32'd298);
        chk("greset_air",   {31'd0, airborne},      32'd0);
        chk("greset_behav", {31'd0, dino_behavior}, 32'd1);
        duck = 1'b0;
        game_state = 2'd1;
        wait_tick();

        // rst mid-flight, then the next tick lands TCK cycles later
        pulse_jump();
        for (int t = 1; t <= 5; t++) wait_tick();
        rst  = 1'b1;
        duck = 1'b1;
        cyc();
        rst = 1'b0;
        chk("rst_fl_pos",   {22'd0, pos},           32'd298);
        chk("rst_fl_behav", {31'd0, dino_behavior}, 32'd1);
        chk("rst_fl_air",   {31'd0, airborne},      32'd0);
        n = 0;
        while (dino_behavior !== 1'b0 && n < 3 * TCK) begin
            cyc();
            n++;
        end
        chk("rst_next_tick", n, TCK);
        duck = 1'b0;
        wait_tick();

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            jump = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 15) == 0) duck = ~duck;
            if ($urandom_range(0, 59) == 0) begin
                case ($urandom_range(0, 5))
                    0:       game_state = 2'd0;
                    1:       game_state = 2'd2;
                    2:       game_state = 2'd3;
                    default: game_state = 2'd1;
                endcase
            end
            rst = ($urandom_range(0, 399) == 0);
            cyc();
        end
        rst  = 1'b0;
        jump = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dino_motion_ctrl.md
DINO_MOTION_CTRL -- requirements
Module: dino_motion_ctrl

Interface
REQ-001 SHALL have parameter TICK_CYCLES, default 1000000, clk cycles per physics tick (100 Hz at 100 MHz).
REQ-002 SHALL have parameter GROUND, default 298, resting value of pos (dino foot row).
REQ-003 SHALL have parameter JUMP_V0, default 12, initial upward velocity in rows/tick.
REQ-004 SHALL have parameter GRAVITY, default 1, velocity decrement per tick in normal flight.
REQ-005 SHALL have parameter FAST_G, default 3, velocity decrement per tick while duck held in flight.
REQ-006 SHALL have port clk, input, 1, system clock; single clock domain.
REQ-007 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-008 SHALL have port jump, input, 1, one-cycle jump request pulse (already debounced).
REQ-009 SHALL have port duck, input, 1, duck button level.
REQ-010 SHALL have port game_state, input, 2, 0=INIT, 1=START, 2=END, 3=RESET.
REQ-011 SHALL have port pos, output, 10, dino foot row, registered, consumed by the dino renderer.
REQ-012 SHALL have port dino_behavior, output, 1, 1=stand, 0=sit, registered.
REQ-013 SHALL have port airborne, output, 1, high while in flight, registered.

Function
REQ-014 SHALL keep a tick counter 0..TICK_CYCLES-1 that wraps and asserts an internal tick for one cycle at TICK_CYCLES-1.
REQ-015 SHALL implement states RUN, DUCK, AIR; all state, pos and velocity updates occur only on tick cycles, except under REQ-023/REQ-024.
REQ-016 SHALL latch a jump pulse into a pending flag on any cycle; the flag clears on the next tick whether or not the jump is taken.
REQ-017 SHALL hold velocity as signed 8-bit, positive = upward; pos arithmetic uses 11-bit signed intermediate.
REQ-018 RUN/DUCK on tick, game_state START: pending jump -> AIR, vel=JUMP_V0-GRAVITY, pos=GROUND-JUMP_V0; else duck=1 -> DUCK; else RUN.
REQ-019 Jump pending and duck both asserted on ground at a tick SHALL take the jump.
REQ-020 AIR on tick: next=pos-vel; if next>=GROUND then pos=GROUND, vel=0, state=DUCK if duck else RUN; else pos=next, vel=vel-(duck?FAST_G:GRAVITY).
REQ-021 Jump pending while in AIR SHALL be ignored (no double jump).
REQ-022 game_state INIT SHALL hold pos=GROUND, state RUN, ignore jump and duck.
REQ-023 game_state END SHALL freeze pos, state, velocity and outputs on the cycle it is seen, ignoring ticks.
REQ-024 game_state RESET SHALL force, on the next clk edge, pos=GROUND, vel=0, state RUN, pending cleared, tick counter unchanged.
REQ-025 Outputs: dino_behavior=0 only in DUCK, else 1; airborne=1 only in AIR; outputs update one clk after the causing tick (registered).
REQ-026 pos SHALL never exceed GROUND and never underflow below 0 for legal parameters (JUMP_V0*(JUMP_V0+1)/2 < GROUND).

Reset
REQ-027 rst SHALL set pos=GROUND, dino_behavior=1, airborne=0, state RUN, vel=0, pending=0, tick counter=0 on the next clk edge.
REQ-028 rst asserted mid-flight SHALL abort the jump identically to REQ-027; rst has priority over all other inputs.

Verification
REQ-029 TICK_CYCLES=4, START, jump pulse -> next tick pos=286, airborne=1; peak pos=220 held for ticks 12-13; tick 25 pos=298, airborne=0.
REQ-030 START, duck held on ground -> dino_behavior=0 one clk after tick; release -> 1 after the following tick; pos stays 298.
REQ-031 Jump, then duck asserted at pos=220 -> descent uses FAST_G; lands before tick 25 with pos clamped to exactly 298, dino_behavior=0 after landing.
REQ-032 Second jump pulse at tick 5 of flight -> trajectory identical to single jump; jump pulse in INIT -> pos stays 298.
REQ-033 game_state->END at pos=250 -> pos holds 250 for 10 ticks; game_state->RESET -> pos=298, airborne=0 next clk.
REQ-034 rst for one cycle during flight -> pos=298, dino_behavior=1, airborne=0 next clk; next tick arrives TICK_CYCLES cycles later.
